// File: rtl/uart_cmd_parser_if.sv
// Signal bundle between uart_if and the monitor command parser.
// The slave side is the parser; the master side is the UART/memory/CPU environment.
interface uart_cmd_parser_if #(
    parameter int unsigned ADR_W = 16
);
    logic [7:0]       rout;
    logic             rout_en;
    logic             flushing_wq;
    logic             mem_rd_en;
    logic [ADR_W-1:0] mem_radr;
    logic [23:0]      mem_rdata;
    logic             mem_wen;
    logic [ADR_W-1:0] mem_wadr;
    logic [23:0]      mem_wdata;
    logic             cpu_run_start;
    logic [ADR_W-1:0] cpu_start_adr;
    logic             cpu_stop;
    logic             rdata_snd_start;
    logic [23:0]      rdata_snd;
    logic             cpust_start;
    logic             crlf_in;

    modport master (
        output rout, rout_en, flushing_wq, mem_rdata,
        input  mem_rd_en, mem_radr, mem_wen, mem_wadr, mem_wdata,
        input  cpu_run_start, cpu_start_adr, cpu_stop,
        input  rdata_snd_start, rdata_snd, cpust_start, crlf_in
    );

    modport slave (
        input  rout, rout_en, flushing_wq, mem_rdata,
        output mem_rd_en, mem_radr, mem_wen, mem_wadr, mem_wdata,
        output cpu_run_start, cpu_start_adr, cpu_stop,
        output rdata_snd_start, rdata_snd, cpust_start, crlf_in
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Monitor command decoder: assembles r/w/g/q/p hex-argument commands from received
// characters, issues memory/CPU strobes and reply triggers, then waits for the reply flush.
module uart_cmd_parser #(
    parameter int unsigned ADR_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    uart_cmd_parser_if.slave  bus
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAdr    = 3'd1;
    localparam logic [2:0] StDat    = 3'd2;
    localparam logic [2:0] StArg0   = 3'd3;
    localparam logic [2:0] StErr    = 3'd4;
    localparam logic [2:0] StExec   = 3'd5;
    localparam logic [2:0] StRdWait = 3'd6;
    localparam logic [2:0] StSend   = 3'd7;

    localparam logic [7:0] ChR  = 8'h72;
    localparam logic [7:0] ChW  = 8'h77;
    localparam logic [7:0] ChG  = 8'h67;
    localparam logic [7:0] ChQ  = 8'h71;
    localparam logic [7:0] ChP  = 8'h70;
    localparam logic [7:0] ChCr = 8'h0d;
    localparam logic [7:0] ChLf = 8'h0a;
    localparam logic [7:0] ChSp = 8'h20;

    logic [2:0]       r_state, w_state_d;
    logic [7:0]       r_cmd, w_cmd_d;
    logic [ADR_W-1:0] r_adr_acc, w_adr_acc_d;
    logic [23:0]      r_dat_acc, w_dat_acc_d;
    logic             r_adr_seen, w_adr_seen_d;
    logic             r_dat_seen, w_dat_seen_d;

    logic             r_mem_rd_en, r_mem_wen, r_cpu_run_start, r_cpu_stop;
    logic             r_rdata_snd_start, r_cpust_start, r_crlf_in;
    logic [ADR_W-1:0] r_mem_radr, r_mem_wadr, r_cpu_start_adr;
    logic [23:0]      r_mem_wdata, r_rdata_snd;

    logic             w_ch, w_is_dec, w_is_alpha, w_is_digit, w_is_cr, w_is_sp, w_is_cmd;
    logic [3:0]       w_nibble;
    logic             w_go_exec, w_go_crlf;
    logic             w_exec_r, w_exec_w, w_exec_g, w_exec_q, w_exec_p;

    // Character classification; LF is invisible in every state.
    always_comb begin
        w_ch       = bus.rout_en && (bus.rout != ChLf);
        w_is_dec   = (bus.rout >= 8'h30) && (bus.rout <= 8'h39);
        w_is_alpha = ((bus.rout >= 8'h61) && (bus.rout <= 8'h66)) ||
                     ((bus.rout >= 8'h41) && (bus.rout <= 8'h46));
        w_is_digit = w_is_dec || w_is_alpha;
        w_nibble   = w_is_dec ? bus.rout[3:0] : bus.rout[3:0] + 4'd9;
        w_is_cr    = (bus.rout == ChCr);
        w_is_sp    = (bus.rout == ChSp);
        w_is_cmd   = (bus.rout == ChR) || (bus.rout == ChW) || (bus.rout == ChG) ||
                     (bus.rout == ChQ) || (bus.rout == ChP);
    end

    always_comb begin
        w_state_d    = r_state;
        w_cmd_d      = r_cmd;
        w_adr_acc_d  = r_adr_acc;
        w_dat_acc_d  = r_dat_acc;
        w_adr_seen_d = r_adr_seen;
        w_dat_seen_d = r_dat_seen;
        w_go_exec    = 1'b0;
        w_go_crlf    = 1'b0;
        case (r_state)
            StIdle: if (w_ch) begin
                if (w_is_cmd) begin
                    w_cmd_d      = bus.rout;
                    w_adr_acc_d  = '0;
                    w_dat_acc_d  = '0;
                    w_adr_seen_d = 1'b0;
                    w_dat_seen_d = 1'b0;
                    w_state_d    = ((bus.rout == ChQ) || (bus.rout == ChP)) ? StArg0 : StAdr;
                end else if (w_is_cr) begin
                    w_go_crlf = 1'b1;
                    w_state_d = StSend;
                end else if (!w_is_sp) begin
                    w_state_d = StErr;
                end
            end
            StAdr: if (w_ch) begin
                if (w_is_digit) begin
                    w_adr_acc_d  = {r_adr_acc[ADR_W-5:0], w_nibble};
                    w_adr_seen_d = 1'b1;
                end else if (w_is_sp) begin
                    if (r_adr_seen) w_state_d = (r_cmd == ChW) ? StDat : StErr;
                end else if (w_is_cr) begin
                    w_go_exec = r_adr_seen;
                    w_go_crlf = !r_adr_seen;
                    w_state_d = r_adr_seen ? StExec : StSend;
                end else begin
                    w_state_d = StErr;
                end
            end
            StDat: if (w_ch) begin
                if (w_is_digit) begin
                    w_dat_acc_d  = {r_dat_acc[19:0], w_nibble};
                    w_dat_seen_d = 1'b1;
                end else if (w_is_cr) begin
                    w_go_exec = r_dat_seen;
                    w_go_crlf = !r_dat_seen;
                    w_state_d = r_dat_seen ? StExec : StSend;
                end else begin
                    w_state_d = StErr;
                end
            end
            StArg0: if (w_ch) begin
                if (w_is_cr) begin
                    w_go_exec = 1'b1;
                    w_state_d = StExec;
                end else begin
                    w_state_d = StErr;
                end
            end
            StErr: if (w_ch && w_is_cr) begin
                w_go_crlf = 1'b1;
                w_state_d = StSend;
            end
            StExec:   w_state_d = (r_cmd == ChR) ? StRdWait : StSend;
            StRdWait: w_state_d = StSend;
            StSend:   if (bus.flushing_wq) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Strobes are registered on the accepting CR so they appear in the EXEC cycle.
    always_comb begin
        w_exec_r = w_go_exec && (r_cmd == ChR);
        w_exec_w = w_go_exec && (r_cmd == ChW);
        w_exec_g = w_go_exec && (r_cmd == ChG);
        w_exec_q = w_go_exec && (r_cmd == ChQ);
        w_exec_p = w_go_exec && (r_cmd == ChP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= StIdle;
            r_cmd             <= '0;
            r_adr_acc         <= '0;
            r_dat_acc         <= '0;
            r_adr_seen        <= 1'b0;
            r_dat_seen        <= 1'b0;
            r_mem_rd_en       <= 1'b0;
            r_mem_radr        <= '0;
            r_mem_wen         <= 1'b0;
            r_mem_wadr        <= '0;
            r_mem_wdata       <= '0;
            r_cpu_run_start   <= 1'b0;
            r_cpu_start_adr   <= '0;
            r_cpu_stop        <= 1'b0;
            r_rdata_snd_start <= 1'b0;
            r_rdata_snd       <= '0;
            r_cpust_start     <= 1'b0;
            r_crlf_in         <= 1'b0;
        end else begin
            r_state           <= w_state_d;
            r_cmd             <= w_cmd_d;
            r_adr_acc         <= w_adr_acc_d;
            r_dat_acc         <= w_dat_acc_d;
            r_adr_seen        <= w_adr_seen_d;
            r_dat_seen        <= w_dat_seen_d;
            r_mem_rd_en       <= w_exec_r;
            r_mem_radr        <= w_exec_r ? r_adr_acc : '0;
            r_mem_wen         <= w_exec_w;
            r_mem_wadr        <= w_exec_w ? r_adr_acc : '0;
            r_mem_wdata       <= w_exec_w ? r_dat_acc : '0;
            r_cpu_run_start   <= w_exec_g;
            r_cpu_stop        <= w_exec_q;
            r_cpust_start     <= w_exec_p;
            r_crlf_in         <= w_go_crlf || w_exec_w || w_exec_g || w_exec_q;
            r_rdata_snd_start <= (r_state == StRdWait);
            if (w_exec_g) r_cpu_start_adr <= r_adr_acc;
            if (r_state == StRdWait) r_rdata_snd <= bus.mem_rdata;
        end
    end

    assign bus.mem_rd_en       = r_mem_rd_en;
    assign bus.mem_radr        = r_mem_radr;
    assign bus.mem_wen         = r_mem_wen;
    assign bus.mem_wadr        = r_mem_wadr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.cpu_run_start   = r_cpu_run_start;
    assign bus.cpu_start_adr   = r_cpu_start_adr;
    assign bus.cpu_stop        = r_cpu_stop;
    assign bus.rdata_snd_start = r_rdata_snd_start;
    assign bus.rdata_snd       = r_rdata_snd;
    assign bus.cpust_start     = r_cpust_start;
    assign bus.crlf_in         = r_crlf_in;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: command table plus hand-written timing, flush and reset sequences.
// In command strings '.' stands for CR and '~' for LF.
module tb_uart_cmd_parser;
    localparam int unsigned ADR_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_parser_if #(.ADR_W(ADR_W)) bus ();

    uart_cmd_parser #(.ADR_W(ADR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 24'habcdef;
        return {a[7:0], ~a[7:0], 8'h5a};
    endfunction

    // Synchronous read memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem_word(bus.mem_radr);
    end

    typedef struct {
        logic [95:0] s;
        int          rd, wen, run, stop, cpust, crlf, snd;
        logic [31:0] adr;
        logic [31:0] dat;
    } vec_t;

    vec_t vecs[14];

    int n_cmp = 0;
    int n_bad = 0;
    int c_rd, c_wen, c_run, c_stop, c_cpust, c_crlf, c_snd, c_leak;
    logic [31:0] l_radr, l_wadr, l_wdata, l_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        c_rd = 0; c_wen = 0; c_run = 0; c_stop = 0;
        c_cpust = 0; c_crlf = 0; c_snd = 0; c_leak = 0;
        l_radr = '0; l_wadr = '0; l_wdata = '0; l_rdata = '0;
    endtask

    // Advance to the next falling edge and tally whatever the DUT shows there.
    task automatic tick();
        @(negedge clk);
        if (bus.mem_rd_en) begin
            c_rd++;
            l_radr = 32'(bus.mem_radr);
        end else if (bus.mem_radr != '0) c_leak++;
        if (bus.mem_wen) begin
            c_wen++;
            l_wadr  = 32'(bus.mem_wadr);
            l_wdata = 32'(bus.mem_wdata);
        end else if (bus.mem_wadr != '0 || bus.mem_wdata != '0) c_leak++;
        if (bus.cpu_run_start) c_run++;
        if (bus.cpu_stop) c_stop++;
        if (bus.cpust_start) c_cpust++;
        if (bus.crlf_in) c_crlf++;
        if (bus.rdata_snd_start) begin
            c_snd++;
            l_rdata = 32'(bus.rdata_snd);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        bus.rout    = c;
        bus.rout_en = 1'b1;
        tick();
        bus.rout_en = 1'b0;
        bus.rout    = 8'h00;
    endtask

    task automatic send_str(input logic [95:0] s);
        logic [7:0] c;
        for (int i = 11; i >= 0; i--) begin
            c = s[i*8 +: 8];
            if (c == 8'h2e) send_char(8'h0d);
            else if (c == 8'h7e) send_char(8'h0a);
            else if (c != 8'h00) send_char(c);
        end
    endtask

    task automatic flush();
        bus.flushing_wq = 1'b1;
        tick();
        bus.flushing_wq = 1'b0;
        tick();
    endtask

    initial begin
        //            string           rd wen run stop cpust crlf snd adr         dat
        vecs[0]  = '{"r10.",           1, 0,  0,  0,   0,    0,   1,  32'h10,    32'habcdef};
        vecs[1]  = '{"w2 1234567.",    0, 1,  0,  0,   0,    1,   0,  32'h2,     32'h234567};
        vecs[2]  = '{"g40.",           0, 0,  1,  0,   0,    1,   0,  32'h40,    32'h0};
        vecs[3]  = '{"q.",             0, 0,  0,  1,   0,    1,   0,  32'h0,     32'h0};
        vecs[4]  = '{"p.",             0, 0,  0,  0,   1,    0,   0,  32'h0,     32'h0};
        vecs[5]  = '{"x1.",            0, 0,  0,  0,   0,    1,   0,  32'h0,     32'h0};
        vecs[6]  = '{"r.",             0, 0,  0,  0,   0,    1,   0,  32'h0,     32'h0};
        vecs[7]  = '{"g1 2.",          0, 0,  0,  0,   0,    1,   0,  32'h0,     32'h0};
        vecs[8]  = '{".",              0, 0,  0,  0,   0,    1,   0,  32'h0,     32'h0};
        vecs[9]  = '{"rA~b.",          1, 0,  0,  0,   0,    0,   1,  32'hab,    32'hab545a};
        vecs[10] = '{"w 12345 fF.",    0, 1,  0,  0,   0,    1,   0,  32'h2345,  32'hff};
        vecs[11] = '{" p.",            0, 0,  0,  0,   1,    0,   0,  32'h0,     32'h0};
        vecs[12] = '{"w5 .",           0, 0,  0,  0,   0,    1,   0,  32'h0,     32'h0};
        vecs[13] = '{"pz.",            0, 0,  0,  0,   0,    1,   0,  32'h0,     32'h0};

        bus.rout = 8'h00; bus.rout_en = 1'b0; bus.flushing_wq = 1'b0;
        rst_n = 1'b0;
        clear_counts();
        tick(); tick();
        check("reset crlf_in", 32'(bus.crlf_in), 32'h0);
        check("reset cpu_start_adr", 32'(bus.cpu_start_adr), 32'h0);
        check("reset rdata_snd", 32'(bus.rdata_snd), 32'h0);
        check("reset strobes", 32'({bus.mem_rd_en, bus.mem_wen, bus.cpu_run_start,
                                    bus.cpu_stop, bus.rdata_snd_start, bus.cpust_start}), 32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            clear_counts();
            send_str(vecs[i].s);
            repeat (5) tick();
            check($sformatf("v%0d rd", i),    32'(c_rd),    32'(vecs[i].rd));
            check($sformatf("v%0d wen", i),   32'(c_wen),   32'(vecs[i].wen));
            check($sformatf("v%0d run", i),   32'(c_run),   32'(vecs[i].run));
            check($sformatf("v%0d stop", i),  32'(c_stop),  32'(vecs[i].stop));
            check($sformatf("v%0d cpust", i), 32'(c_cpust), 32'(vecs[i].cpust));
            check($sformatf("v%0d crlf", i),  32'(c_crlf),  32'(vecs[i].crlf));
            check($sformatf("v%0d snd", i),   32'(c_snd),   32'(vecs[i].snd));
            check($sformatf("v%0d leak", i),  32'(c_leak),  32'h0);
            if (vecs[i].rd > 0) begin
                check($sformatf("v%0d radr", i),  l_radr,  vecs[i].adr);
                check($sformatf("v%0d rdata", i), l_rdata, vecs[i].dat);
            end
            if (vecs[i].wen > 0) begin
                check($sformatf("v%0d wadr", i),  l_wadr,  vecs[i].adr);
                check($sformatf("v%0d wdata", i), l_wdata, vecs[i].dat);
            end
            if (vecs[i].run > 0)
                check($sformatf("v%0d start_adr", i), 32'(bus.cpu_start_adr), vecs[i].adr);
            flush();
        end
        check("start_adr held", 32'(bus.cpu_start_adr), 32'h40);

        // Read latency: strobe at T+1, reply trigger at T+3.
        clear_counts();
        send_char(8'h72); send_char(8'h31); send_char(8'h30);
        bus.rout = 8'h0d; bus.rout_en = 1'b1;
        tick();
        bus.rout_en = 1'b0;
        check("rd T+1 en", 32'(bus.mem_rd_en), 32'h1);
        check("rd T+1 adr", 32'(bus.mem_radr), 32'h10);
        check("rd T+1 snd", 32'(bus.rdata_snd_start), 32'h0);
        tick();
        check("rd T+2 en", 32'(bus.mem_rd_en), 32'h0);
        check("rd T+2 snd", 32'(bus.rdata_snd_start), 32'h0);
        tick();
        check("rd T+3 snd", 32'(bus.rdata_snd_start), 32'h1);
        check("rd T+3 data", 32'(bus.rdata_snd), 32'habcdef);
        clear_counts();
        send_str("r3.");
        repeat (4) tick();
        check("send hold rd", 32'(c_rd + c_snd + c_crlf), 32'h0);
        check("send hold data", 32'(bus.rdata_snd), 32'habcdef);
        flush();

        // Characters are dropped in SEND, including one arriving with flushing_wq.
        clear_counts();
        send_str("p.");
        check("p first cpust", 32'(c_cpust), 32'h1);
        send_str("p.");
        repeat (3) tick();
        check("p dropped", 32'(c_cpust), 32'h1);
        bus.rout = 8'h78; bus.rout_en = 1'b1; bus.flushing_wq = 1'b1;
        tick();
        bus.rout_en = 1'b0; bus.flushing_wq = 1'b0;
        clear_counts();
        send_str("p.");
        tick();
        check("p after flush cpust", 32'(c_cpust), 32'h1);
        check("p after flush crlf", 32'(c_crlf), 32'h0);
        flush();

        // flushing_wq outside SEND is ignored.
        clear_counts();
        send_char(8'h70);
        flush();
        send_char(8'h0d);
        tick();
        check("flush in ARG0 ignored", 32'(c_cpust), 32'h1);
        flush();

        // Reset in the middle of a write command.
        clear_counts();
        send_char(8'h77); send_char(8'h35);
        rst_n = 1'b0;
        #1;
        check("mid rst wen", 32'({bus.mem_wen, bus.mem_rd_en, bus.crlf_in}), 32'h0);
        check("mid rst wadr/wdata", 32'(bus.mem_wadr) | 32'(bus.mem_wdata), 32'h0);
        check("mid rst start_adr", 32'(bus.cpu_start_adr), 32'h0);
        check("mid rst rdata_snd", 32'(bus.rdata_snd), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        send_str("r3.");
        repeat (4) tick();
        check("post rst rd", 32'(c_rd), 32'h1);
        check("post rst radr", l_radr, 32'h3);
        check("post rst wen", 32'(c_wen), 32'h0);
        check("post rst rdata", l_rdata, 32'h03fc5a);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
